// File: rtl/ext_alu_arb_pkg.sv
// Shared encodings for the extended ALU and its two-port front end.
package ext_alu_arb_pkg;

  typedef enum logic [2:0] {
    FN_MUL   = 3'b000,
    FN_UMUL  = 3'b001,
    FN_ADDF  = 3'b010,
    FN_SUBF  = 3'b011,
    FN_MULF  = 3'b100,
    FN_ITF   = 3'b101,
    FN_FTI   = 3'b110,
    FN_UNDEF = 3'b111
  } func_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2
  } state_e;

  function automatic logic [3:0] lat_load(input int lat);
    return 4'(lat - 1);
  endfunction

endpackage

// File: rtl/ext_alu_arb_rr_arb2.sv
// Two-port round-robin grant; a tie goes to the port not served last.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last; // 1 means port 1 was served most recently

  assign gnt0 = en & req0 & (~req1 | last);
  assign gnt1 = en & req1 & (~req0 | ~last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (gnt0) begin
      last <= 1'b0;
    end else if (gnt1) begin
      last <= 1'b1;
    end
  end

endmodule

// File: rtl/ext_alu_arb.sv
// Arbitrates CPU and accelerator access to a shared multi-cycle extended ALU
// and returns each result to the port that issued it.
module ext_alu_arb
  import ext_alu_arb_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_vld,
  input  logic [31:0] req0_src0,
  input  logic [31:0] req0_src1,
  input  logic [2:0]  req0_func,
  input  logic        req1_vld,
  input  logic [31:0] req1_src0,
  input  logic [31:0] req1_src1,
  input  logic [2:0]  req1_func,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rsp0_vld,
  output logic        rsp1_vld,
  output logic [31:0] rsp_data,
  output logic        rsp_ov,
  output logic        rsp_zr,
  output logic        rsp_neg,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] alu_src0,
  output logic [31:0] alu_src1,
  output logic [2:0]  alu_func,
  input  logic [31:0] alu_dst,
  input  logic        alu_ov,
  input  logic        alu_zr,
  input  logic        alu_neg
);

  localparam logic [3:0] LAT_LOAD = lat_load(LAT);

  state_e      state;
  logic [3:0]  cnt;
  logic        owner;
  logic        undef;
  logic [31:0] sel_src0;
  logic [31:0] sel_src1;
  logic [2:0]  sel_func;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (state == ST_IDLE),
    .req0 (req0_vld),
    .req1 (req1_vld),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  always_comb begin
    sel_src0 = req0_src0;
    sel_src1 = req0_src1;
    sel_func = req0_func;
    if (gnt1) begin
      sel_src0 = req1_src0;
      sel_src1 = req1_src1;
      sel_func = req1_func;
    end
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      owner    <= 1'b0;
      undef    <= 1'b0;
      alu_src0 <= 32'd0;
      alu_src1 <= 32'd0;
      alu_func <= 3'd0;
      rsp0_vld <= 1'b0;
      rsp1_vld <= 1'b0;
      rsp_data <= 32'd0;
      rsp_ov   <= 1'b0;
      rsp_zr   <= 1'b0;
      rsp_neg  <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      rsp0_vld <= 1'b0;
      rsp1_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt0 | gnt1) begin
            owner <= gnt1;
            // Undefined ops never reach the ALU, so its operands stay untouched.
            if (func_e'(sel_func) == FN_UNDEF) begin
              undef <= 1'b1;
              state <= ST_CAPT;
            end else begin
              undef    <= 1'b0;
              alu_src0 <= sel_src0;
              alu_src1 <= sel_src1;
              alu_func <= sel_func;
              cnt      <= LAT_LOAD;
              state    <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (cnt == 4'd0) begin
            state <= ST_CAPT;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_CAPT: begin
          if (undef) begin
            rsp_data <= 32'd0;
            rsp_ov   <= 1'b0;
            rsp_zr   <= 1'b0;
            rsp_neg  <= 1'b0;
            rsp_err  <= 1'b1;
          end else begin
            rsp_data <= alu_dst;
            rsp_ov   <= alu_ov;
            rsp_zr   <= alu_zr;
            rsp_neg  <= alu_neg;
            rsp_err  <= 1'b0;
          end
          rsp0_vld <= ~owner;
          rsp1_vld <= owner;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ext_alu_arb.md
EXT_ALU_ARB -- requirements
Module: ext_alu_arb

Interface
REQ-001 Parameter LAT, default 1, meaning cycles from operands stable on alu_* outputs to result valid on alu_dst; legal range 1..15.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_vld  input  1  CPU port request; held high with operands stable until granted.
REQ-005 req0_src0, req0_src1  input  32 each  CPU operands.
REQ-006 req0_func  input  3  CPU op code, same encoding as extended ALU: 000 MUL, 001 UMUL, 010 ADDF, 011 SUBF, 100 MULF, 101 ITF, 110 FTI, 111 undefined.
REQ-007 req1_vld, req1_src0, req1_src1, req1_func  input  1/32/32/3  accelerator port, same meaning as port 0.
REQ-008 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands latched on that edge.
REQ-009 rsp0_vld, rsp1_vld  output  1 each  one-cycle response pulse to the owning port.
REQ-010 rsp_data  output  32  result, shared by both ports, valid while rspN_vld is high.
REQ-011 rsp_ov, rsp_zr, rsp_neg, rsp_err  output  1 each  flags; rsp_err flags an undefined func.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 alu_src0, alu_src1  output  32 each  registered operands to extended ALU.
REQ-014 alu_func  output  3  registered op code to extended ALU.
REQ-015 alu_dst  input  32  extended ALU result.
REQ-016 alu_ov, alu_zr, alu_neg  input  1 each  extended ALU flags.

Function
REQ-017 FSM states IDLE, EXEC, CAPT; one operation in flight at most.
REQ-018 IDLE: no request -> stay; any request -> assert gnt for the selected port combinationally, latch src0/src1/func and owner onto alu_* registers and an owner register, go to EXEC (func 111 goes directly to CAPT).
REQ-019 Arbitration: a sole requester wins; on simultaneous requests the port not served last wins (round-robin); last-served pointer updates on each grant.
REQ-020 EXEC: 4-bit counter loaded with LAT-1 at grant, decrements each cycle; at 0 go to CAPT.
REQ-021 CAPT: register alu_dst and flags into rsp_* (rsp_err=0), or for func 111 rsp_data=0, flags 0, rsp_err=1; go to IDLE.
REQ-022 Response: rspN_vld (owner only) high for exactly the cycle after CAPT; grant at cycle T -> response at T+LAT+2 (T+2 for func 111).
REQ-023 A new grant may occur in the same cycle a response is presented, giving a back-to-back issue interval of LAT+2 cycles.
REQ-024 alu_* outputs and rsp_data and flags hold their values until next overwritten; gnt0 and gnt1 never high together; gnt never asserted outside IDLE.
REQ-025 Requests arriving while busy are not dropped; they are served in IDLE per REQ-019.

Reset
REQ-026 rst asserted: state IDLE, counter 0, gnt*, rsp*_vld, busy = 0, alu_* = 0, rsp_data and flags = 0, last-served pointer = port 1 (port 0 wins first tie).
REQ-027 Reset mid-operation aborts the operation; no response is ever issued for it after rst deasserts.

Structure
REQ-028 Shared package holds the func encoding enum (7 ops + undefined) and the FSM state enum; extended ALU and this block import it.
REQ-029 Round-robin two-port grant logic is one natural sub-module, rr_arb2; everything else is flat.

Verification
REQ-030 LAT=1, port 0 MUL src0=3, src1=0xFFFFFFFE, grant cycle T -> rsp0_vld at T+3, rsp_data=0xFFFFFFFA, rsp_neg=1, rsp_err=0, rsp1_vld stays 0.
REQ-031 Both ports request from the first cycle after reset -> gnt0 first, gnt1 at the rsp0 cycle, each response to its owner only.
REQ-032 Both ports held requesting for 6 operations -> grants alternate 0,1,0,1,0,1 at LAT+2 spacing with no idle cycle.
REQ-033 Port 1 ADDF 0x3F800000 + 0xBF800000 -> rsp1_vld with rsp_data=0, rsp_zr=1.
REQ-034 Port 0 func 111 -> rsp0_vld at T+2, rsp_err=1, rsp_data=0, alu_func unchanged from the previous operation.
REQ-035 LAT=3, rst pulsed during EXEC -> all outputs 0 immediately; no rsp*_vld after release; the next request is granted normally.
